// File: rtl/jk_bank_arbiter_if.sv
// jk_bank_arbiter_if: request/command/status bundle for the JK cell bank.
// The slave modport is used by jk_bank_arbiter; the master modport by its requesters.
// The lock signal exists only when JK_BANK_LOCK_EN is defined.
interface jk_bank_arbiter_if #(
    parameter int NREQ = 4,
    parameter int NFF  = 6,
    parameter int IDXW = (NFF > 1) ? $clog2(NFF) : 1,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      cmd_j;
    logic [NREQ-1:0]      cmd_k;
    logic [NREQ*IDXW-1:0] cmd_idx;
`ifdef JK_BANK_LOCK_EN
    logic [NREQ-1:0]      lock;
`endif
    logic [NREQ-1:0]      gnt;
    logic                 done;
    logic [IDW-1:0]       done_id;
    logic                 err;
    logic                 busy;
    logic [NFF-1:0]       q;
    logic [NFF-1:0]       qb;

`ifdef JK_BANK_LOCK_EN
    modport master (output req, cmd_j, cmd_k, cmd_idx, lock,
                    input  gnt, done, done_id, err, busy, q, qb);
    modport slave  (input  req, cmd_j, cmd_k, cmd_idx, lock,
                    output gnt, done, done_id, err, busy, q, qb);
`else
    modport master (output req, cmd_j, cmd_k, cmd_idx,
                    input  gnt, done, done_id, err, busy, q, qb);
    modport slave  (input  req, cmd_j, cmd_k, cmd_idx,
                    output gnt, done, done_id, err, busy, q, qb);
`endif
endinterface

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: bank of NFF JK cells shared by NREQ requesters through a
// round-robin arbiter. One command at a time: IDLE (capture) -> GRANT ->
// APPLY (cell update) -> ACK (done pulse), four cycles per command.
// Optional feature macro: JK_BANK_LOCK_EN (keep-grant lock per requester).
module jk_bank_arbiter #(
    parameter int NREQ = 4,
    parameter int NFF  = 6,
    parameter int IDXW = (NFF > 1) ? $clog2(NFF) : 1
) (
    input  logic               clk,
    input  logic               rst,
    jk_bank_arbiter_if.slave   bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_APPLY = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_win;
    logic               r_j;
    logic               r_k;
    logic [IDXW-1:0]    r_idx;
    logic [NFF-1:0]     r_q;
    logic [NREQ-1:0]    r_gnt;
    logic               r_done;
    logic [IDW-1:0]     r_done_id;
    logic               r_err;
    logic               r_busy;
`ifdef JK_BANK_LOCK_EN
    logic               r_locked;
`endif

    logic [IDW-1:0]     w_base;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_idx_k;
    logic               w_found;
    logic               w_sel_j;
    logic               w_sel_k;
    logic [IDXW-1:0]    w_sel_idx;
    logic [NREQ-1:0]    w_gnt_vec;
    logic               w_oor;
    int                 v_sum;

    // Next requester id after v, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] v);
        int t;
        t = int'(v) + 1;
        if (t >= NREQ) begin
            t = 0;
        end
        return IDW'(t);
    endfunction

    // JK cell next-state: hold, reset, set, toggle.
    function automatic logic jk_next(input logic q_cur, input logic j, input logic k);
        logic r;
        case ({j, k})
            2'b00:   r = q_cur;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            2'b11:   r = ~q_cur;
            default: r = q_cur;
        endcase
        return r;
    endfunction

    // Round-robin winner: first set req bit scanning upward from the base pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx_k = '0;
        v_sum   = 0;
`ifdef JK_BANK_LOCK_EN
        // A dropped lock resumes rotation just after the previously locked requester.
        w_base = r_locked ? next_id(r_win) : r_ptr;
`else
        w_base = r_ptr;
`endif
        for (int k = 0; k < NREQ; k++) begin
            v_sum = int'(w_base) + k;
            if (v_sum >= NREQ) begin
                v_sum = v_sum - NREQ;
            end else begin
                v_sum = v_sum;
            end
            w_idx_k = IDW'(v_sum);
            if (!w_found && bus.req[w_idx_k]) begin
                w_win   = w_idx_k;
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
`ifdef JK_BANK_LOCK_EN
        // A locked requester that still requests wins outright.
        if (r_locked && bus.req[r_win]) begin
            w_win   = r_win;
            w_found = 1'b1;
        end else begin
            w_found = w_found;
        end
`endif
    end

    // Select the winner's command fields and build its one-hot grant vector.
    always_comb begin
        w_sel_j   = 1'b0;
        w_sel_k   = 1'b0;
        w_sel_idx = '0;
        w_gnt_vec = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (IDW'(r) == w_win) begin
                w_sel_j      = bus.cmd_j[r];
                w_sel_k      = bus.cmd_k[r];
                w_sel_idx    = bus.cmd_idx[r*IDXW +: IDXW];
                w_gnt_vec[r] = 1'b1;
            end else begin
                w_gnt_vec[r] = 1'b0;
            end
        end
    end

    // Captured index outside the bank: no cell is written and err is flagged.
    assign w_oor = ({{(32-IDXW){1'b0}}, r_idx} >= 32'(NFF));

    // Command sequencer: capture, grant, apply to one cell, acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_j       <= 1'b0;
            r_k       <= 1'b0;
            r_idx     <= '0;
            r_q       <= '0;
            r_gnt     <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
`ifdef JK_BANK_LOCK_EN
            r_locked  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
`ifdef JK_BANK_LOCK_EN
                    if (r_locked && !bus.req[r_win]) begin
                        r_locked <= 1'b0;
                        r_ptr    <= next_id(r_win);
                    end
`endif
                    if (w_found) begin
                        r_win   <= w_win;
                        r_j     <= w_sel_j;
                        r_k     <= w_sel_k;
                        r_idx   <= w_sel_idx;
                        r_gnt   <= w_gnt_vec;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end else begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    r_gnt   <= '0;
                    r_state <= S_APPLY;
                end
                S_APPLY: begin
                    for (int f = 0; f < NFF; f++) begin
                        if (!w_oor && (r_idx == IDXW'(f))) begin
                            r_q[f] <= jk_next(r_q[f], r_j, r_k);
                        end
                    end
                    r_done    <= 1'b1;
                    r_err     <= w_oor;
                    r_done_id <= r_win;
                    r_state   <= S_ACK;
                end
                S_ACK: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`ifdef JK_BANK_LOCK_EN
                    if (bus.lock[r_win]) begin
                        r_locked <= 1'b1;
                    end else begin
                        r_locked <= 1'b0;
                        r_ptr    <= next_id(r_win);
                    end
`else
                    r_ptr <= next_id(r_win);
`endif
                end
                default: begin
                    r_gnt   <= '0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.err     = r_err;
    assign bus.busy    = r_busy;
    assign bus.q       = r_q;
    assign bus.qb      = ~r_q;

endmodule
